uart_rx_cfg: RTL and testbench

Parametrised next-generation UART receiver for the DSO command link. It supports configurable data width, parity, stop-bit count and baud divisor. It rejects false starts, reports parity, framing and overrun errors, and allows back-to-back frames. It sits between the RX pin synchroniser boundary and the command processor, using the same rdy/clr_rdy handshake as the existing receiver.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_baud_cnt.sv | 39 +++
 rtl/uart_rx_cfg.sv | 187 ++++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the configurable UART receiver.
//   rx_state_t : receiver FSM states
//   PAR_*      : parity mode encodings used by the PARITY parameter
//   maj3       : 2-of-3 vote used by the glitch-filtered sampling build
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-timing counter for the UART receiver.
// Ports:
//   clk       : system clock
//   rst       : synchronous active-high reset
//   clr       : restart the count at zero (takes priority over en)
//   en        : count while high
//   half_tick : count is at the middle of a bit (BAUD_DIV/2-1)
//   full_tick : count is at the last cycle of a bit (BAUD_DIV-1); wraps to 0
module uart_baud_cnt #(
    parameter int BAUD_DIV = 44
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic half_tick,
    output logic full_tick
);

    localparam int CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] HALF_M1 = CW'(BAUD_DIV / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(BAUD_DIV - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= full_tick ? '0 : count + CW'(1);
        end
    end

    assign half_tick = en && (count == HALF_M1);
    assign full_tick = en && (count == FULL_M1);

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver for the DSO command link.
// Build option: define UART_RX_MAJORITY_EN to take every bit sample as the
// 2-of-3 majority of the last three synchronised RX values.
// Ports:
//   clk         : system clock
//   rst         : synchronous active-high reset
//   RX          : asynchronous serial input, idles high
//   clr_rdy     : consumer acknowledge; clears rdy and all flags
//   rx_data     : last received data word (LSB first on the line)
//   rdy         : a frame is waiting in rx_data
//   parity_err  : parity mismatch on the frame in rx_data
//   framing_err : a stop bit was sampled low on the frame in rx_data
//   overrun     : a frame completed while rdy was still set (sticky)
//
// state  | meaning
// -------+-----------------------------------------------
// IDLE   | line idle, waiting for a falling edge
// START  | timing to mid start bit to reject false starts
// DATA   | sampling DATA_BITS data bits, one per bit time
// PARITY | sampling the parity bit
// STOP   | sampling STOP_BITS stop bits
module uart_rx_cfg #(
    parameter int DATA_BITS = 8,
    parameter int BAUD_DIV  = 44,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 RX,
    input  logic                 clr_rdy,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rdy,
    output logic                 parity_err,
    output logic                 framing_err,
    output logic                 overrun
);

    import uart_pkg::*;

    // The PARITY parameter hides the imported state of the same name, so
    // that state is always referenced with the package scope.
    localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);
    localparam logic       ODD_PAR   = (PARITY == PAR_ODD);

    rx_state_t state, state_nxt;

    logic sync1, sync, prev;
    logic fall, samp;
    logic half_tick, full_tick;
    logic [3:0] bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic par_acc, frm_acc, done;

    // Reset high so a low RX right after reset does not look like an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b1;
            sync  <= 1'b1;
            prev  <= 1'b1;
        end else begin
            sync1 <= RX;
            sync  <= sync1;
            prev  <= sync;
        end
    end

    assign fall = prev & ~sync;

`ifdef UART_RX_MAJORITY_EN
    logic prev2;

    always_ff @(posedge clk) begin
        if (rst) begin
            prev2 <= 1'b1;
        end else begin
            prev2 <= prev;
        end
    end

    assign samp = maj3(sync, prev, prev2);
`else
    assign samp = sync;
`endif

    uart_baud_cnt #(
        .BAUD_DIV (BAUD_DIV)
    ) u_baud_cnt (
        .clk       (clk),
        .rst       (rst),
        .clr       (state_nxt != state),
        .en        (state != IDLE),
        .half_tick (half_tick),
        .full_tick (full_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (fall) state_nxt = START;
            end
            START: begin
                if (half_tick) state_nxt = samp ? IDLE : DATA;
            end
            DATA: begin
                if (full_tick && bit_cnt == LAST_DATA) begin
                    state_nxt = (PARITY != PAR_NONE) ? uart_pkg::PARITY : STOP;
                end
            end
            uart_pkg::PARITY: begin
                if (full_tick) state_nxt = STOP;
            end
            STOP: begin
                // Leave at mid stop bit so the next start edge is not missed.
                if (full_tick && bit_cnt == LAST_STOP) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt <= '0;
            shreg   <= '0;
            par_acc <= 1'b0;
            frm_acc <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state_nxt != state) begin
                bit_cnt <= '0;
            end else if (full_tick && (state == DATA || state == STOP)) begin
                bit_cnt <= bit_cnt + 4'd1;
            end
            if (state == IDLE && fall) begin
                par_acc <= 1'b0;
                frm_acc <= 1'b0;
            end
            if (state == DATA && full_tick) begin
                shreg <= {samp, shreg[DATA_BITS-1:1]};
            end
            if (state == uart_pkg::PARITY && full_tick) begin
                par_acc <= (^shreg) ^ samp ^ ODD_PAR;
            end
            if (state == STOP && full_tick) begin
                if (!samp) frm_acc <= 1'b1;
                if (bit_cnt == LAST_STOP) done <= 1'b1;
            end
        end
    end

    // A completing frame overrides a same-cycle clr_rdy.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data     <= '0;
            rdy         <= 1'b0;
            parity_err  <= 1'b0;
            framing_err <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            if (clr_rdy) begin
                rdy         <= 1'b0;
                parity_err  <= 1'b0;
                framing_err <= 1'b0;
                overrun     <= 1'b0;
            end
            if (done) begin
                rx_data     <= shreg;
                parity_err  <= par_acc;
                framing_err <= frm_acc;
                rdy         <= 1'b1;
                if (rdy && !clr_rdy) overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Self-checking bench for uart_rx_cfg. Three receivers with different
// configurations are driven by bit-level serial stimulus; a frame-level
// model predicts rx_data, flags and rdy latency.
module tb_uart_rx_cfg;

    localparam int NB [3] = '{8, 9, 7};
    localparam int BD [3] = '{44, 16, 12};
    localparam int PM [3] = '{0, 1, 2};
    localparam int NS [3] = '{1, 1, 2};

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] rx;
    logic [2:0] clr;
    logic [2:0] rdy_v, perr_v, ferr_v, ovr_v;
    logic [7:0] d0;
    logic [8:0] d1;
    logic [6:0] d2;

    int n_chk = 0;
    int n_err = 0;

    logic [8:0] exp_data [3];
    logic [2:0] exp_rdy, exp_perr, exp_ferr, exp_ovr;
    time        t_start [3];
    time        t_rise  [3];
    logic [2:0] rdy_d = 3'b000;
    int         k0;

    always #5 clk = ~clk;

    uart_rx_cfg u_dut0 (
        .clk(clk), .rst(rst), .RX(rx[0]), .clr_rdy(clr[0]), .rx_data(d0),
        .rdy(rdy_v[0]), .parity_err(perr_v[0]), .framing_err(ferr_v[0]), .overrun(ovr_v[0])
    );

    uart_rx_cfg #(.DATA_BITS(9), .BAUD_DIV(16), .PARITY(1), .STOP_BITS(1)) u_dut1 (
        .clk(clk), .rst(rst), .RX(rx[1]), .clr_rdy(clr[1]), .rx_data(d1),
        .rdy(rdy_v[1]), .parity_err(perr_v[1]), .framing_err(ferr_v[1]), .overrun(ovr_v[1])
    );

    uart_rx_cfg #(.DATA_BITS(7), .BAUD_DIV(12), .PARITY(2), .STOP_BITS(2)) u_dut2 (
        .clk(clk), .rst(rst), .RX(rx[2]), .clr_rdy(clr[2]), .rx_data(d2),
        .rdy(rdy_v[2]), .parity_err(perr_v[2]), .framing_err(ferr_v[2]), .overrun(ovr_v[2])
    );

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rdy_v[i] && !rdy_d[i]) t_rise[i] = $time;
        end
        rdy_d = rdy_v;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [8:0] get_data(input int u);
        case (u)
            0:       return {1'b0, d0};
            1:       return d1;
            default: return {2'b00, d2};
        endcase
    endfunction

    function automatic logic [8:0] dmask(input int u);
        return 9'((1 << NB[u]) - 1);
    endfunction

    function automatic int exp_lat(input int u);
        int p;
        p = (PM[u] != 0) ? 1 : 0;
        return ((2 * (NB[u] + p + NS[u]) + 1) * BD[u]) / 2 + 3;
    endfunction

    task automatic check_out(input int u, input string tag);
        chk($sformatf("%s.u%0d.data", tag, u), 32'(get_data(u)), 32'(exp_data[u]));
        chk($sformatf("%s.u%0d.rdy", tag, u), 32'(rdy_v[u]), 32'(exp_rdy[u]));
        chk($sformatf("%s.u%0d.parity_err", tag, u), 32'(perr_v[u]), 32'(exp_perr[u]));
        chk($sformatf("%s.u%0d.framing_err", tag, u), 32'(ferr_v[u]), 32'(exp_ferr[u]));
        chk($sformatf("%s.u%0d.overrun", tag, u), 32'(ovr_v[u]), 32'(exp_ovr[u]));
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) exp_data[i] = '0;
        exp_rdy = '0; exp_perr = '0; exp_ferr = '0; exp_ovr = '0;
    endtask

    task automatic model_clear(input int u);
        exp_rdy[u] = 1'b0; exp_perr[u] = 1'b0; exp_ferr[u] = 1'b0; exp_ovr[u] = 1'b0;
    endtask

    // Frame completion: parity judged from data plus received parity bit.
    task automatic model_frame(input int u, input logic [8:0] data, input logic pbit,
                               input bit [1:0] stop_lo);
        logic x;
        x = (^(data & dmask(u))) ^ pbit;
        exp_ovr[u]  = exp_ovr[u] | exp_rdy[u];
        exp_rdy[u]  = 1'b1;
        exp_data[u] = data & dmask(u);
        exp_perr[u] = (PM[u] == 1) ? x : (PM[u] == 2) ? ~x : 1'b0;
        exp_ferr[u] = (NS[u] == 2) ? (stop_lo[0] | stop_lo[1]) : stop_lo[0];
    endtask

    task automatic drive_bit(input int u, input logic v, input int goff);
        for (int c = 0; c < BD[u]; c++) begin
            rx[u] = (c == goff) ? ~v : v;
            @(negedge clk);
        end
    endtask

    task automatic send_frame(input int u, input logic [8:0] data, input bit bad_par,
                              input bit [1:0] stop_lo, input int gap, input bit glitch,
                              output logic pbit);
        int goff;
        goff = glitch ? BD[u] / 2 : -1;
        pbit = (^(data & dmask(u))) ^ (PM[u] == 2) ^ bad_par;
        t_rise[u] = 0;
        @(negedge clk);
        rx[u] = 1'b0;
        t_start[u] = $time;
        repeat (BD[u]) @(negedge clk);
        for (int i = 0; i < NB[u]; i++) drive_bit(u, data[i], goff);
        if (PM[u] != 0) drive_bit(u, pbit, -1);
        for (int s = 0; s < NS[u]; s++) drive_bit(u, ~stop_lo[s], -1);
        rx[u] = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    task automatic do_clr(input int u, input string tag);
        @(negedge clk);
        clr[u] = 1'b1;
        @(negedge clk);
        clr[u] = 1'b0;
        model_clear(u);
        check_out(u, tag);
    endtask

    // Measured in negedges from start edge drive to rdy observation.
    task automatic lat_check(input int u, input string tag, output int k);
        int lat;
        int e;
        e   = exp_lat(u);
        lat = (t_rise[u] == 0) ? -1 : int'((t_rise[u] - t_start[u]) / 10) - 1;
        k   = lat + 1;
        chk($sformatf("%s.u%0d.latency", tag, u),
            32'((lat >= e - 1 && lat <= e + 1) ? e : lat), 32'(e));
    endtask

    task automatic rand_frame(input int u, input string tag);
        logic [8:0] d;
        bit bp;
        bit [1:0] sl;
        logic pb;
        d  = 9'($urandom_range(0, 511));
        bp = (PM[u] != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
        sl = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        send_frame(u, d, bp, sl, 2 * BD[u], 1'b0, pb);
        model_frame(u, d, pb, sl);
        check_out(u, tag);
        do_clr(u, {tag, "_clr"});
    endtask

    initial begin
        logic pb;
        int   kd;
        rst = 1'b1;
        rx  = 3'b111;
        clr = 3'b000;
        model_reset();
        repeat (4) @(negedge clk);
        rst = 1'b0;
        for (int u = 0; u < 3; u++) check_out(u, "reset");

        // default 8N1
        send_frame(0, 9'h0A5, 1'b0, 2'b00, 2 * BD[0], 1'b0, pb);
        model_frame(0, 9'h0A5, pb, 2'b00);
        check_out(0, "a5");
        lat_check(0, "a5", k0);
        if (k0 < 2 || k0 > 2000) k0 = exp_lat(0) + 1;
        do_clr(0, "a5_clr");

        // false start then a real frame
        @(negedge clk);
        rx[0] = 1'b0;
        repeat (10) @(negedge clk);
        rx[0] = 1'b1;
        repeat (3 * BD[0]) @(negedge clk);
        chk("false_start.rdy", 32'(rdy_v[0]), 32'(exp_rdy[0]));
        send_frame(0, 9'h03C, 1'b0, 2'b00, 2 * BD[0], 1'b0, pb);
        model_frame(0, 9'h03C, pb, 2'b00);
        check_out(0, "after_false");
        do_clr(0, "after_false_clr");

        for (int i = 0; i < 4; i++) rand_frame(0, $sformatf("rnd0_%0d", i));

        // back-to-back without acknowledge
        send_frame(0, 9'h011, 1'b0, 2'b00, 0, 1'b0, pb);
        model_frame(0, 9'h011, pb, 2'b00);
        send_frame(0, 9'h022, 1'b0, 2'b00, 2 * BD[0], 1'b0, pb);
        model_frame(0, 9'h022, pb, 2'b00);
        check_out(0, "overrun");
        do_clr(0, "overrun_clr");

        // acknowledge in the same cycle a new frame completes
        send_frame(0, 9'h077, 1'b0, 2'b00, 2 * BD[0], 1'b0, pb);
        model_frame(0, 9'h077, pb, 2'b00);
        fork
            send_frame(0, 9'h096, 1'b0, 2'b00, 2 * BD[0], 1'b0, pb);
            begin
                @(negedge clk);
                repeat (k0 - 1) @(negedge clk);
                clr[0] = 1'b1;
                @(negedge clk);
                chk("simul.rdy", 32'(rdy_v[0]), 32'd1);
                chk("simul.overrun", 32'(ovr_v[0]), 32'd0);
                chk("simul.data", 32'(get_data(0)), 32'h96);
                clr[0] = 1'b0;
            end
        join
        model_clear(0);
        model_frame(0, 9'h096, pb, 2'b00);
        check_out(0, "simul_after");
        do_clr(0, "simul_clr");

        // 9 data bits, even parity
        send_frame(1, 9'h03C, 1'b1, 2'b00, 2 * BD[1], 1'b0, pb);
        model_frame(1, 9'h03C, pb, 2'b00);
        check_out(1, "par_bad");
        lat_check(1, "par_bad", kd);
        do_clr(1, "par_bad_clr");
        send_frame(1, 9'h03C, 1'b0, 2'b00, 2 * BD[1], 1'b0, pb);
        model_frame(1, 9'h03C, pb, 2'b00);
        check_out(1, "par_ok");
        do_clr(1, "par_ok_clr");
        for (int i = 0; i < 5; i++) rand_frame(1, $sformatf("rnd1_%0d", i));

        // 7 data bits, odd parity, two stop bits
        send_frame(2, 9'h05B, 1'b0, 2'b10, 2 * BD[2], 1'b0, pb);
        model_frame(2, 9'h05B, pb, 2'b10);
        check_out(2, "stop2_low");
        lat_check(2, "stop2_low", kd);
        do_clr(2, "stop2_clr");
        for (int i = 0; i < 6; i++) rand_frame(2, $sformatf("rnd2_%0d", i));

`ifdef UART_RX_MAJORITY_EN
        send_frame(0, 9'h05A, 1'b0, 2'b00, 2 * BD[0], 1'b1, pb);
        model_frame(0, 9'h05A, pb, 2'b00);
        check_out(0, "glitch");
        do_clr(0, "glitch_clr");
`endif

        // reset in the middle of a frame, with an unacknowledged frame pending
        send_frame(0, 9'h0C3, 1'b0, 2'b00, 2 * BD[0], 1'b0, pb);
        model_frame(0, 9'h0C3, pb, 2'b00);
        @(negedge clk);
        rx[0] = 1'b0;
        repeat (3 * BD[0]) @(negedge clk);
        rst   = 1'b1;
        rx[0] = 1'b1;
        @(negedge clk);
        model_reset();
        for (int u = 0; u < 3; u++) check_out(u, "midrst");
        rst = 1'b0;
        repeat (2 * BD[0]) @(negedge clk);
        send_frame(0, 9'h05A, 1'b0, 2'b00, 2 * BD[0], 1'b0, pb);
        model_frame(0, 9'h05A, pb, 2'b00);
        check_out(0, "post_rst");
        lat_check(0, "post_rst", kd);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
